// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async FIFO and its read-side consumers.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_PACK_MAX   = 8;

  // Smallest r such that 2**r >= value (returns 1 for value <= 2 so counters stay at least 1 bit).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Byte-enable mask covering lanes 0..lane-1.
  function automatic logic [FIFO_PACK_MAX-1:0] keep_mask(input int lane);
    return FIFO_PACK_MAX'((1 << lane) - 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops bytes, packs PACK of them little-endian into one word,
// and presents words on a valid/ready port; flush emits a trailing partial word with a keep mask.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PACK       = 4
) (
  input  logic                       clkb,
  input  logic                       reset,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rd_en,
  input  logic                       flush,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int              LW   = clog2(PACK);
  localparam int              WW   = PACK * DATA_WIDTH;
  localparam logic [LW-1:0]   LAST = LW'(PACK - 1);
  localparam logic [LW:0]     PACK_W = (LW + 1)'(PACK);

  logic [LW-1:0]         r_lane;
  logic                  r_pend;
  logic                  r_flush_pend;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_acc [PACK];
  logic [WW-1:0]         r_out_data;
  logic [PACK-1:0]       r_out_keep;
  logic                  r_out_valid;

  logic [LW:0]           w_lane_sum;
  logic [LW-1:0]         w_eff_lane;
  logic                  w_out_free;
  logic                  w_rd_en;
  logic                  w_complete;
  logic                  w_flush_fire;
  logic                  w_flush_emit;
  logic [WW-1:0]         w_full_word;
  logic [WW-1:0]         w_part_word;
  logic [PACK-1:0]       w_part_keep;

  // Lane the next requested byte will occupy, counting the one already in flight.
  always_comb begin
    w_lane_sum = {1'b0, r_lane} + (LW + 1)'(r_pend);
    if (w_lane_sum >= PACK_W) begin
      w_eff_lane = LW'(w_lane_sum - PACK_W);
    end else begin
      w_eff_lane = w_lane_sum[LW-1:0];
    end
  end

  assign w_out_free   = ~r_out_valid | out_ready;
  // A request that would complete a word is only issued when the output register will be free.
  assign w_rd_en      = r_run & ~empty & ~r_flush_pend & ~flush &
                        ((w_eff_lane != LAST) | w_out_free);
  assign w_complete   = r_pend & (r_lane == LAST);
  assign w_flush_fire = r_flush_pend & ~r_pend & w_out_free;
  assign w_flush_emit = w_flush_fire & (r_lane != '0);

  always_comb begin
    w_full_word = '0;
    w_part_word = '0;
    w_part_keep = PACK'(keep_mask(int'(r_lane)));
    for (int i = 0; i < PACK - 1; i++) begin
      w_full_word[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i];
    end
    w_full_word[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = rdata;
    // Stale bytes above the fill level must not leak into a partial word.
    for (int i = 0; i < PACK; i++) begin
      if (w_part_keep[i]) begin
        w_part_word[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i];
      end
    end
  end

  always_ff @(posedge clkb) begin
    if (!reset) begin
      r_lane       <= '0;
      r_pend       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_run        <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_valid  <= 1'b0;
      for (int i = 0; i < PACK; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_run  <= 1'b1;
      r_pend <= w_rd_en;

      if (r_pend) begin
        r_acc[r_lane] <= rdata;
        r_lane        <= (r_lane == LAST) ? '0 : r_lane + LW'(1);
      end else if (w_flush_emit) begin
        r_lane <= '0;
      end

      if (w_flush_fire) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_complete) begin
        r_out_data  <= w_full_word;
        r_out_keep  <= '1;
        r_out_valid <= 1'b1;
      end else if (w_flush_emit) begin
        r_out_data  <= w_part_word;
        r_out_keep  <= w_part_keep;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign rd_en     = w_rd_en;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_valid = r_out_valid;
  assign busy      = (r_lane != '0) | r_pend | r_out_valid | r_flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: behavioural FIFO model, word capture, per-scenario checks.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  logic            clkb = 1'b0;
  logic            reset = 1'b0;
  logic            empty;
  logic [DW-1:0]   rdata = '0;
  logic            rd_en;
  logic            flush = 1'b0;
  logic [PK*DW-1:0] out_data;
  logic [PK-1:0]   out_keep;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;

  int nvec = 0;
  int nmis = 0;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clkb(clkb), .reset(reset), .empty(empty), .rdata(rdata), .rd_en(rd_en),
    .flush(flush), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clkb = ~clkb;

  // FIFO model: rdata registered one cycle after a successful pop.
  logic [7:0] fmem [256];
  int         wptr = 0;
  int         rptr = 0;
  logic       fifo_clr = 1'b0;
  assign empty = (wptr == rptr);

  always @(posedge clkb) begin
    if (fifo_clr) begin
      rptr <= wptr;
    end else if (rd_en && !empty) begin
      rdata <= fmem[rptr];
      rptr  <= rptr + 1;
    end
  end

  // Event log: pops, out_valid rising edges, accepted words.
  int          cyc = 0;
  int          npop = 0;
  int          ncap = 0;
  int          nrise = 0;
  logic        prev_v = 1'b0;
  int          pop_cyc [128];
  int          rise_cyc [64];
  logic [31:0] cap_data [16];
  logic [3:0]  cap_keep [16];

  always @(posedge clkb) begin
    if (rd_en && !empty) begin
      if (npop < 128) pop_cyc[npop] = cyc;
      npop++;
    end
    if (out_valid === 1'b1 && !prev_v) begin
      if (nrise < 64) rise_cyc[nrise] = cyc;
      nrise++;
    end
    prev_v = (out_valid === 1'b1);
    if (out_valid === 1'b1 && out_ready) begin
      if (ncap < 16) begin
        cap_data[ncap] = out_data;
        cap_keep[ncap] = out_keep;
      end
      ncap++;
    end
    cyc++;
  end

  task automatic push(input logic [7:0] b);
    fmem[wptr] = b;
    wptr++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push(8'h55);
    for (int k = 0; k < 4; k++) begin
      @(negedge clkb);
      nvec++;
      if (rd_en !== 1'b0) begin nmis++; $display("FAIL reset_rd_en cyc%0d: got %b expected 0", k, rd_en); end
      nvec++;
      if (out_valid !== 1'b0) begin nmis++; $display("FAIL reset_out_valid cyc%0d: got %b expected 0", k, out_valid); end
      nvec++;
      if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy cyc%0d: got %b expected 0", k, busy); end
    end
    nvec++;
    if (out_data !== 32'h0 || out_keep !== 4'h0) begin
      nmis++; $display("FAIL reset_out_regs: got data %h keep %h expected 0 0", out_data, out_keep);
    end
    fifo_clr = 1'b1;
    @(negedge clkb);
    fifo_clr = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clkb);
  endtask

  task automatic test_stream();
    int bp, bc, br;
    bp = npop; bc = ncap; br = nrise;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int k = 0; k < 40 && ncap < bc + 2; k++) @(negedge clkb);
    nvec++;
    if (ncap - bc !== 2) begin nmis++; $display("FAIL stream_words: got %0d expected 2", ncap - bc); end
    nvec++;
    if (cap_data[bc] !== 32'h04030201 || cap_keep[bc] !== 4'hF) begin
      nmis++; $display("FAIL stream_w0: got %h/%h expected 04030201/f", cap_data[bc], cap_keep[bc]);
    end
    nvec++;
    if (cap_data[bc+1] !== 32'h08070605 || cap_keep[bc+1] !== 4'hF) begin
      nmis++; $display("FAIL stream_w1: got %h/%h expected 08070605/f", cap_data[bc+1], cap_keep[bc+1]);
    end
    nvec++;
    if (npop - bp !== 8 || pop_cyc[bp+7] - pop_cyc[bp] !== 7) begin
      nmis++; $display("FAIL stream_pop_run: got %0d pops span %0d expected 8 span 7",
                       npop - bp, pop_cyc[bp+7] - pop_cyc[bp]);
    end
    nvec++;
    if (nrise <= br || rise_cyc[br] - pop_cyc[bp] !== 5) begin
      nmis++; $display("FAIL stream_latency: got %0d expected 5", rise_cyc[br] - pop_cyc[bp]);
    end
    repeat (2) @(negedge clkb);
    nvec++;
    if (busy !== 1'b0) begin nmis++; $display("FAIL stream_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int bp, bc;
    bp = npop; bc = ncap;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
    repeat (30) @(negedge clkb);
    nvec++;
    if (npop - bp !== 7) begin nmis++; $display("FAIL bp_pops_held: got %0d expected 7", npop - bp); end
    nvec++;
    if (rd_en !== 1'b0) begin nmis++; $display("FAIL bp_rd_en_held: got %b expected 0", rd_en); end
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 32'h13121110) begin
      nmis++; $display("FAIL bp_out_held: got %b/%h expected 1/13121110", out_valid, out_data);
    end
    nvec++;
    if (busy !== 1'b1 || ncap - bc !== 0) begin
      nmis++; $display("FAIL bp_busy_nocap: got busy %b words %0d expected 1 0", busy, ncap - bc);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 40 && ncap < bc + 3; k++) @(negedge clkb);
    nvec++;
    if (ncap - bc !== 3 || npop - bp !== 12) begin
      nmis++; $display("FAIL bp_counts: got %0d words %0d pops expected 3 12", ncap - bc, npop - bp);
    end
    nvec++;
    if (cap_data[bc] !== 32'h13121110) begin nmis++; $display("FAIL bp_w0: got %h expected 13121110", cap_data[bc]); end
    nvec++;
    if (cap_data[bc+1] !== 32'h17161514) begin nmis++; $display("FAIL bp_w1: got %h expected 17161514", cap_data[bc+1]); end
    nvec++;
    if (cap_data[bc+2] !== 32'h1B1A1918) begin nmis++; $display("FAIL bp_w2: got %h expected 1b1a1918", cap_data[bc+2]); end
    repeat (2) @(negedge clkb);
  endtask

  task automatic test_flush_partial();
    int bc;
    bc = ncap;
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (6) @(negedge clkb);
    nvec++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      nmis++; $display("FAIL partial_pre: got valid %b busy %b expected 0 1", out_valid, busy);
    end
    flush = 1'b1;
    @(negedge clkb);
    flush = 1'b0;
    for (int k = 0; k < 20 && ncap < bc + 1; k++) @(negedge clkb);
    repeat (4) @(negedge clkb);
    nvec++;
    if (ncap - bc !== 1) begin nmis++; $display("FAIL partial_count: got %0d expected 1", ncap - bc); end
    nvec++;
    if (cap_data[bc] !== 32'h00A3A2A1 || cap_keep[bc] !== 4'h7) begin
      nmis++; $display("FAIL partial_word: got %h/%h expected 00a3a2a1/7", cap_data[bc], cap_keep[bc]);
    end
    nvec++;
    if (busy !== 1'b0) begin nmis++; $display("FAIL partial_busy: got %b expected 0", busy); end
  endtask

  task automatic test_flush_empty();
    int bc;
    bc = ncap;
    flush = 1'b1;
    @(negedge clkb);
    flush = 1'b0;
    nvec++;
    if (busy !== 1'b1) begin nmis++; $display("FAIL flush_empty_pend: got %b expected 1", busy); end
    repeat (6) @(negedge clkb);
    nvec++;
    if (ncap - bc !== 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      nmis++; $display("FAIL flush_empty_noword: got words %0d valid %b busy %b expected 0 0 0",
                       ncap - bc, out_valid, busy);
    end
  endtask

  task automatic test_flush_coincident();
    int bp, bc;
    bp = npop; bc = ncap;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    for (int k = 0; k < 20 && npop < bp + 4; k++) @(negedge clkb);
    nvec++;
    if (npop - bp !== 4) begin nmis++; $display("FAIL coinc_pops: got %0d expected 4", npop - bp); end
    flush = 1'b1;
    @(negedge clkb);
    flush = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || out_keep !== 4'hF || out_data !== 32'hB4B3B2B1) begin
      nmis++; $display("FAIL coinc_full_first: got %b/%h/%h expected 1/f/b4b3b2b1", out_valid, out_keep, out_data);
    end
    repeat (6) @(negedge clkb);
    nvec++;
    if (ncap - bc !== 1 || busy !== 1'b0) begin
      nmis++; $display("FAIL coinc_only_one: got words %0d busy %b expected 1 0", ncap - bc, busy);
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    push(8'hD1); push(8'hD2); push(8'hD3);
    repeat (3) @(negedge clkb);
    reset = 1'b0;
    @(negedge clkb);
    nvec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || out_keep !== 4'h0) begin
      nmis++; $display("FAIL midrst_state: got valid %b busy %b rd_en %b keep %h expected 0 0 0 0",
                       out_valid, busy, rd_en, out_keep);
    end
    reset = 1'b1;
    bc = ncap;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    for (int k = 0; k < 30 && ncap < bc + 1; k++) @(negedge clkb);
    repeat (3) @(negedge clkb);
    nvec++;
    if (ncap - bc !== 1 || cap_data[bc] !== 32'hE4E3E2E1 || cap_keep[bc] !== 4'hF) begin
      nmis++; $display("FAIL midrst_fresh: got %0d words %h/%h expected 1 e4e3e2e1/f",
                       ncap - bc, cap_data[bc], cap_keep[bc]);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_coincident();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
